// File: rtl/hazard_pkg.sv
// Shared constants and state types for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_MEM = 3'd1;
    localparam logic [2:0] WB_PC4 = 3'd2;
    localparam logic [2:0] WB_HI  = 3'd3;
    localparam logic [2:0] WB_LO  = 3'd4;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {M_IDLE, M_BUSY} mult_state_t;
    typedef enum logic {C_RUN, C_MISS} cache_state_t;

    // True when the D instruction reads the HI/LO product registers.
    function automatic logic is_hilo(input logic [2:0] wbsrc);
        return (wbsrc == WB_HI) || (wbsrc == WB_LO);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational operand forwarding selects for the D-stage branch compare
// and the E-stage ALU inputs. Register 0 never forwards.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rsd,
    input  logic [4:0] rtd,
    input  logic [4:0] rse,
    input  logic [4:0] rte,
    input  logic [4:0] writeregm,
    input  logic [4:0] writeregw,
    input  logic       regwritem,
    input  logic       regwritew,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    always_comb begin
        ForwardAE = FWD_RF;
        if (rse != '0 && regwritem && writeregm == rse)
            ForwardAE = FWD_M;
        else if (rse != '0 && regwritew && writeregw == rse)
            ForwardAE = FWD_W;

        ForwardBE = FWD_RF;
        if (rte != '0 && regwritem && writeregm == rte)
            ForwardBE = FWD_M;
        else if (rte != '0 && regwritew && writeregw == rte)
            ForwardBE = FWD_W;

        ForwardAD = (rsd != '0) && regwritem && (writeregm == rsd);
        ForwardBD = (rtd != '0) && regwritem && (writeregm == rtd);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller with multiplier and data-cache miss tracking.
// Optional HAZARD_PERF_CNT_EN adds saturating stall and miss cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rsd,
    input  logic [4:0] rtd,
    input  logic [4:0] rse,
    input  logic [4:0] rte,
    input  logic [4:0] writerege,
    input  logic [4:0] writeregm,
    input  logic [4:0] writeregw,
    input  logic       regwritee,
    input  logic       regwritem,
    input  logic       regwritew,
    input  logic [2:0] wbsrcd,
    input  logic [2:0] wbsrce,
    input  logic [2:0] wbsrcm,
    input  logic       branchd,
    input  logic       multstartd,
    input  logic       multstarte,
    input  logic       prodv,
    input  logic       memwritem,
    input  logic       dcache_ready,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mult_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] miss_cycles
`endif
);

    mult_state_t  mstate;
    cache_state_t cstate;

    logic access;
    logic miss_stall;
    logic lduse_hz;
    logic branch_hz;
    logic mult_hz;
    logic pipe_hz;

    forward_unit u_fwd (
        .rsd       (rsd),
        .rtd       (rtd),
        .rse       (rse),
        .rte       (rte),
        .writeregm (writeregm),
        .writeregw (writeregw),
        .regwritem (regwritem),
        .regwritew (regwritew),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    always_comb begin
        access     = memwritem || (wbsrcm == WB_MEM);
        miss_stall = ((cstate == C_RUN) && access && !dcache_ready) ||
                     ((cstate == C_MISS) && !dcache_ready);

        lduse_hz  = (wbsrce == WB_MEM) && (rte != '0) &&
                    ((rte == rsd) || (rte == rtd));
        branch_hz = branchd &&
                    ((regwritee && ((writerege == rsd) || (writerege == rtd))) ||
                     ((wbsrcm == WB_MEM) && ((writeregm == rsd) || (writeregm == rtd))));

        mult_busy = (mstate == M_BUSY) || multstarte;
        mult_hz   = mult_busy && !prodv && (is_hilo(wbsrcd) || multstartd);

        pipe_hz = lduse_hz || branch_hz || mult_hz;

        // A miss freezes the whole pipe, so D/E must hold rather than take a bubble.
        StallF = miss_stall || pipe_hz;
        StallD = miss_stall || pipe_hz;
        StallE = miss_stall;
        StallM = miss_stall;
        StallW = miss_stall;
        FlushE = !miss_stall && pipe_hz;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstate <= M_IDLE;
        end else begin
            case (mstate)
                M_IDLE:  if (multstarte) mstate <= M_BUSY;
                M_BUSY:  if (prodv && !multstarte) mstate <= M_IDLE;
                default: mstate <= M_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cstate <= C_RUN;
        end else begin
            case (cstate)
                C_RUN:   if (access && !dcache_ready) cstate <= C_MISS;
                C_MISS:  if (dcache_ready) cstate <= C_RUN;
                default: cstate <= C_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            miss_cycles  <= '0;
        end else begin
            if (StallF && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (miss_stall && miss_cycles != '1)
                miss_cycles <= miss_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; define HAZARD_PERF_CNT_EN to also
// exercise the cycle counters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
    logic       regwritee, regwritem, regwritew;
    logic [2:0] wbsrcd, wbsrce, wbsrcm;
    logic       branchd, multstartd, multstarte, prodv, memwritem, dcache_ready;
    logic       StallF, StallD, StallE, StallM, StallW, FlushE;
    logic       ForwardAD, ForwardBD, mult_busy;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, miss_cycles;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [12:0] outs;
    assign outs = {StallF, StallD, StallE, StallM, StallW, FlushE,
                   ForwardAD, ForwardBD, ForwardAE, ForwardBE, mult_busy};

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .rsd          (rsd),
        .rtd          (rtd),
        .rse          (rse),
        .rte          (rte),
        .writerege    (writerege),
        .writeregm    (writeregm),
        .writeregw    (writeregw),
        .regwritee    (regwritee),
        .regwritem    (regwritem),
        .regwritew    (regwritew),
        .wbsrcd       (wbsrcd),
        .wbsrce       (wbsrce),
        .wbsrcm       (wbsrcm),
        .branchd      (branchd),
        .multstartd   (multstartd),
        .multstarte   (multstarte),
        .prodv        (prodv),
        .memwritem    (memwritem),
        .dcache_ready (dcache_ready),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .StallW       (StallW),
        .FlushE       (FlushE),
        .ForwardAD    (ForwardAD),
        .ForwardBD    (ForwardBD),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .mult_busy    (mult_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .miss_cycles  (miss_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rsd = '0; rtd = '0; rse = '0; rte = '0;
        writerege = '0; writeregm = '0; writeregw = '0;
        regwritee = 1'b0; regwritem = 1'b0; regwritew = 1'b0;
        wbsrcd = '0; wbsrce = '0; wbsrcm = '0;
        branchd = 1'b0; multstartd = 1'b0; multstarte = 1'b0;
        prodv = 1'b0; memwritem = 1'b0; dcache_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        check("reset_outs", {19'b0, outs}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("reset_stall_cnt", stall_cycles, 32'd0);
        check("reset_miss_cnt", miss_cycles, 32'd0);
`endif
        step();
        reset = 1'b0;
        step();
        #1;
        check("idle_outs", {19'b0, outs}, 32'd0);

        // E/D forwarding
        regwritem = 1'b1; writeregm = 5'd8; regwritew = 1'b1; writeregw = 5'd8;
        rse = 5'd8; rte = 5'd8; rsd = 5'd8;
        #1;
        check("fwd_ae_m", {30'b0, ForwardAE}, 32'd2);
        check("fwd_be_m", {30'b0, ForwardBE}, 32'd2);
        check("fwd_ad_m", {31'b0, ForwardAD}, 32'd1);
        regwritem = 1'b0;
        #1;
        check("fwd_ae_w", {30'b0, ForwardAE}, 32'd1);
        check("fwd_ad_off", {31'b0, ForwardAD}, 32'd0);
        regwritem = 1'b1; writeregm = '0; writeregw = '0; rse = '0; rte = '0; rsd = '0;
        #1;
        check("fwd_r0_outs", {19'b0, outs}, 32'd0);
        clear_inputs(); dcache_ready = 1'b1;

        // Load-use
        wbsrce = 3'd1; rte = 5'd9; rsd = 5'd9;
        #1;
        check("lduse_outs", {19'b0, outs}, {19'b0, 5'b11000, 1'b1, 7'b0});
        step();
        wbsrce = '0; rte = '0;
        #1;
        check("lduse_bubble", {19'b0, outs}, 32'd0);
        wbsrce = 3'd1; rte = 5'd10;
        #1;
        check("lduse_nodep", {19'b0, outs}, 32'd0);
        clear_inputs(); dcache_ready = 1'b1;

        // Branch dependency on E, then forwarded from M
        branchd = 1'b1; regwritee = 1'b1; writerege = 5'd4; rtd = 5'd4;
        #1;
        check("br_e_outs", {19'b0, outs}, {19'b0, 5'b11000, 1'b1, 7'b0});
        step();
        regwritee = 1'b0; writerege = '0; regwritem = 1'b1; writeregm = 5'd4;
        #1;
        check("br_m_outs", {19'b0, outs}, {19'b0, 5'b00000, 1'b0, 2'b01, 5'b0});
        wbsrcm = 3'd1; regwritem = 1'b0; dcache_ready = 1'b1;
        #1;
        check("br_load_m", {19'b0, outs}, {19'b0, 5'b11000, 1'b1, 7'b0});
        clear_inputs(); dcache_ready = 1'b1;

        // Multiplier occupancy
        multstarte = 1'b1; wbsrcd = 3'd3;
        #1;
        check("mult_start_busy", {31'b0, mult_busy}, 32'd1);
        check("mult_start_stall", {31'b0, StallD}, 32'd1);
        step();
        multstarte = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            check("mult_wait", {30'b0, StallD, mult_busy}, 32'd3);
            step();
        end
        prodv = 1'b1;
        #1;
        check("mult_prodv_stall", {31'b0, StallD}, 32'd0);
        check("mult_prodv_busy", {31'b0, mult_busy}, 32'd1);
        step();
        prodv = 1'b0;
        #1;
        check("mult_done", {19'b0, outs}, 32'd0);
        wbsrcd = '0;
        multstarte = 1'b1;
        step();
        prodv = 1'b1;
        step();
        multstarte = 1'b0; prodv = 1'b0; multstartd = 1'b1;
        #1;
        check("mult_backtoback", {19'b0, outs}, {19'b0, 5'b11000, 1'b1, 6'b0, 1'b1});
        prodv = 1'b1; multstartd = 1'b0;
        step();
        prodv = 1'b0;
        #1;
        check("mult_idle_again", {31'b0, mult_busy}, 32'd0);
        clear_inputs(); dcache_ready = 1'b1;

        // Cache hit then 5-cycle miss with overlapping load-use
        wbsrcm = 3'd1;
        #1;
        check("cache_hit", {19'b0, outs}, 32'd0);
        dcache_ready = 1'b0; wbsrce = 3'd1; rte = 5'd9; rsd = 5'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("miss_hold", {19'b0, outs}, {19'b0, 5'b11111, 8'b0});
            step();
        end
        dcache_ready = 1'b1;
        #1;
        check("miss_release", {19'b0, outs}, {19'b0, 5'b11000, 1'b1, 7'b0});
`ifdef HAZARD_PERF_CNT_EN
        check("miss_cnt5", miss_cycles, 32'd5);
`endif
        step();
        clear_inputs(); dcache_ready = 1'b1;
        memwritem = 1'b1; dcache_ready = 1'b0;
        #1;
        check("store_miss", {29'b0, StallE, StallM, StallW}, 32'd7);
        step();
        memwritem = 1'b0;
        #1;
        check("miss_noaccess_hold", {31'b0, StallW}, 32'd1);
        dcache_ready = 1'b1;
        step();
        dcache_ready = 1'b0;
        #1;
        check("miss_cleared", {19'b0, outs}, 32'd0);

        // Reset during a miss with a multiply in flight
        clear_inputs();
        wbsrcm = 3'd1; multstarte = 1'b1;
        step();
        multstarte = 1'b0;
        step();
        #2;
        clear_inputs();
        #1;
        check("pre_reset_state", {19'b0, outs}, {19'b0, 5'b11111, 7'b0, 1'b1});
        reset = 1'b1;
        #1;
        check("reset_mid_miss", {19'b0, outs}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("reset_miss_cnt2", miss_cycles, 32'd0);
`endif
        step();
        reset = 1'b0;
        wbsrcm = 3'd1; dcache_ready = 1'b1;
        #1;
        check("post_reset_hit", {19'b0, outs}, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core with serial multiplier and data cache. It drives the F/D/E/M/W stall enables, the E flush, and the D/E-stage forwarding selects from register tags and control bits returned by the datapath. It also tracks multiplier occupancy and data-cache miss state so that the datapath holds correctly across multi-cycle events.

## Interface
- No parameters; widths are fixed by the ISA.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `rsd`, `rtd` in 5: D-stage source registers.
- `rse`, `rte` in 5: E-stage source registers.
- `writerege`, `writeregm`, `writeregw` in 5: destination register per stage.
- `regwritee`, `regwritem`, `regwritew` in 1: register write enable per stage.
- `wbsrcd`, `wbsrce`, `wbsrcm` in 3: writeback source per stage.
- `branchd` in 1: D instruction is a branch.
- `multstartd`, `multstarte` in 1: D or E instruction starts a multiply.
- `prodv` in 1: multiplier product valid.
- `memwritem` in 1: M instruction stores.
- `dcache_ready` in 1: cache completes the current M access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM`, `StallW` out 1: hold the stage register.
- `FlushE` out 1: clear the D→E register.
- `ForwardAD`, `ForwardBD` out 1: 1 selects `aluoutm` for the branch compare.
- `ForwardAE`, `ForwardBE` out 2: 00 register file, 01 `resultw`, 10 `aluoutm`.
- `mult_busy` out 1: a multiply is in flight.

## Operation
- **Forwarding** (combinational; register 0 is never matched):
  - `ForwardAE` = 10 if `regwritem` and `writeregm == rse`.
  - Else 01 if `regwritew` and `writeregw == rse`.
  - Else 00.
  - `ForwardBE` follows the same rules using `rte`.
  - `ForwardAD` = `regwritem` and `writeregm == rsd`.
  - `ForwardBD` follows the same rule using `rtd`.
- **Load-use hazard:** `wbsrce == WB_MEM` and `rte` is nonzero and equals `rsd` or `rtd`. Asserts `StallF`, `StallD`, `FlushE`.
- **Branch hazard:** `branchd` and either of:
  - `regwritee` with `writerege` in {`rsd`, `rtd`}, or
  - `wbsrcm == WB_MEM` with `writeregm` in {`rsd`, `rtd`}.
  - Asserts `StallF`, `StallD`, `FlushE`.
- **Multiplier FSM** (M_IDLE, M_BUSY):
  - M_IDLE → M_BUSY on `multstarte`.
  - M_BUSY → M_IDLE on `prodv`. If `prodv` and `multstarte` occur together, stay in M_BUSY.
  - `mult_busy` = M_BUSY or `multstarte`.
  - Multiply hazard: `mult_busy` and not `prodv`, with `wbsrcd` in {WB_HI, WB_LO} or `multstartd`. Asserts `StallF`, `StallD`, `FlushE`.
- **Cache FSM** (C_RUN, C_MISS):
  - An access is `memwritem` or `wbsrcm == WB_MEM`.
  - C_RUN → C_MISS when there is an access and `dcache_ready` is 0.
  - C_MISS → C_RUN when `dcache_ready` is 1.
  - `miss_stall` = (C_RUN with access and not ready) or (C_MISS and not ready).
  - `miss_stall` asserts all five stalls.
- **Priority:**
  - `miss_stall` overrides everything: `FlushE` is forced to 0 so D and E are held, not bubbled.
  - Otherwise the load-use, branch, and multiply hazards are ORed.
- `StallE`, `StallM`, `StallW` are asserted only by `miss_stall`.

## Timing
- Forward selects and stall/flush outputs are combinational from inputs and current state, and are valid in the same cycle.
- FSM state updates on the rising edge of `clk`.
- Reset (async):
  - Both FSMs go to idle/run.
  - With all-zero inputs, every output is 0.
- Cache miss of N cycles (`dcache_ready` low for N cycles): stalls are high for exactly N cycles. The pipeline advances in the cycle `dcache_ready` rises.
- Cache hit (`dcache_ready` = 1 with access in C_RUN): zero stall cycles.
- Load-use and branch hazards cost one bubble each. A load followed by a dependent branch costs two.
- Reset during C_MISS or M_BUSY aborts to idle immediately; no stall persists.

## Configuration
- `HAZARD_PERF_CNT_EN`: when defined, adds 32-bit outputs `stall_cycles` and `miss_cycles`.
  - `stall_cycles` increments each cycle `StallF` is high.
  - `miss_cycles` increments each cycle `miss_stall` is high.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
  - When undefined, the ports and counters do not exist and behaviour is otherwise identical.

## Structure
- `hazard_pkg` holds:
  - WB source constants: WB_ALU=0, WB_MEM=1, WB_PC4=2, WB_HI=3, WB_LO=4.
  - Forward encodings: FWD_RF=00, FWD_W=01, FWD_M=10.
  - Multiplier and cache state enums.
- One sub-module, `forward_unit`, contains the purely combinational AE/BE/AD/BD selection. FSMs and stall merging stay in `hazard_ctrl`.

## Test plan
- **E forwarding:** `regwritem`=1, `writeregm`=8, `regwritew`=1, `writeregw`=8, `rse`=8 → `ForwardAE`=10. With `rse`=0 and both writeregs 0 → `ForwardAE`=00.
- **Load-use:** `wbsrce`=1, `rte`=9, `rsd`=9 → `StallF`=`StallD`=`FlushE`=1 for one cycle, `StallE`=0. With `rte`=10 → no stall.
- **Branch dependency:** `branchd`=1, `regwritee`=1, `writerege`=4, `rtd`=4 → stall one cycle. Next cycle, `regwritem`=1, `writeregm`=4 → no stall and `ForwardBD`=1.
- **Multiplier:** pulse `multstarte`, hold `wbsrcd`=3, `prodv` low for 32 cycles → `StallD` high and `mult_busy`=1 throughout. `prodv`=1 → stall drops the same cycle; `mult_busy`=0 the next cycle.
- **Cache miss:** `wbsrcm`=1, `dcache_ready`=0 for 5 cycles → all stalls high for exactly 5 cycles with `FlushE`=0, while a simultaneous load-use hazard is present. Stalls clear when ready rises.
- **Reset mid-miss:** assert `reset` in cycle 3 of a miss → all outputs 0 asynchronously. After release with `dcache_ready`=1 → no stall. With `HAZARD_PERF_CNT_EN`, `miss_cycles`=0 after reset.
